// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch stage: fetch FSM states,
// the NOP instruction, PC increment and the fetch buffer entry layout.
package cpu_pkg;

  // MIPS sll $0,$0,0 -- presented on the IF/ID interface when nothing is valid.
  localparam logic [31:0] NOP_INSTN = 32'h0000_0000;

  // Byte distance between consecutive instruction words.
  localparam logic [31:0] PC_INCR = 32'd4;

  // S_WAIT: one request is outstanding and its data will be kept.
  // S_DROP: one request is outstanding but a redirect has made it stale.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  // One buffered instruction together with its own address and fall-through address.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instn;
  } fetch_entry_t;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetch entries. Flush empties it and wins over a
// push in the same cycle. The head entry is held in a register that is loaded
// with the post-update head, so the consumer always sees a clean flop output.
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = NOP_INSTN,
  localparam int         PTR_W = $clog2(DEPTH),
  localparam int         CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output logic               empty,
  output logic               full,
  output fetch_entry_t       head
);

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0, pc_plus4: 32'h0, instn: NOP};

  fetch_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count_q;
  fetch_entry_t           head_q;

  logic                   pop_ok;
  logic                   push_ok;
  logic [PTR_W-1:0]       rd_next;
  logic [CNT_W-1:0]       count_next;
  fetch_entry_t           head_next;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = head_q;

  assign pop_ok  = pop && !flush && !empty;
  assign push_ok = push && !flush && (!full || pop_ok);

  // Next read pointer, occupancy and head entry after this cycle's push/pop.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no path
    // leaves it holding its old value and no latch is inferred.
    rd_next    = rd_ptr + PTR_W'(pop_ok);
    count_next = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    head_next  = EMPTY_ENTRY;
    if (flush || count_next == '0) begin
      head_next = EMPTY_ENTRY;
    end else if (push_ok && wr_ptr == rd_next) begin
      // The slot becoming the head is the one being written right now.
      head_next = push_entry;
    end else begin
      head_next = mem[rd_next];
    end
  end

  // Pointers, occupancy and the registered head; flush returns to the empty state.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      head_q  <= EMPTY_ENTRY;
    end else begin
      rd_ptr  <= rd_next;
      wr_ptr  <= wr_ptr + PTR_W'(push_ok);
      count_q <= count_next;
      head_q  <= head_next;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy and the head
    // register guarantee a stale slot is never presented.
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Issues one outstanding request at a time to
// instruction memory, buffers returned words with their PCs, and hands the
// head entry to the IF/ID register. A redirect flushes the buffer, retargets
// the fetch PC and marks any in-flight response as stale.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTN = cpu_pkg::NOP_INSTN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instn,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state;
  logic [31:0]       fetch_pc;
  logic [31:0]       req_pc;
  logic              req_en;

  logic              buf_push;
  logic              buf_pop;
  fetch_entry_t      buf_entry;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_empty;
  logic              buf_full;
  fetch_entry_t      buf_head;

  // The request is combinational so a same-cycle redirect can suppress it.
  // req_en holds requests off for the first cycle after reset.
  assign imem_req  = !reset && req_en && (state == S_REQ) && !redirect_valid &&
                     (buf_count < CNT_W'(DEPTH));
  assign imem_addr = fetch_pc;

  // Responses are kept only while waiting and not being redirected.
  assign buf_push  = (state == S_WAIT) && imem_rvalid && !redirect_valid;
  assign buf_pop   = if_valid && !stall_if && !redirect_valid;
  assign buf_entry = '{pc: req_pc, pc_plus4: req_pc + PC_INCR, instn: imem_rdata};

  assign if_valid    = !buf_empty;
  assign if_instn    = buf_head.instn;
  assign if_pc       = buf_head.pc;
  assign if_pc_plus4 = buf_head.pc_plus4;

  // Fetch FSM: request, wait for data, or drop stale data after a redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      req_en   <= 1'b0;
    end else begin
      req_en <= 1'b1;
      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
        case (state)
          S_WAIT, S_DROP: state <= imem_rvalid ? S_REQ : S_DROP;
          default:        state <= S_REQ;
        endcase
      end else begin
        case (state)
          S_REQ: begin
            if (imem_req && imem_gnt) begin
              fetch_pc <= fetch_pc + PC_INCR;
              req_pc   <= fetch_pc;
              state    <= S_WAIT;
            end
          end
          S_WAIT, S_DROP: begin
            if (imem_rvalid) begin
              state <= S_REQ;
            end
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end

  // A response can never meet a full buffer: requests go out only below DEPTH
  // and occupancy cannot grow while the single request is outstanding.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(buf_push && buf_full));
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH),
    .NOP   (NOP_INSTN)
  ) u_fetch_buffer (
    .clk        (clk),
    .reset      (reset),
    .push       (buf_push),
    .push_entry (buf_entry),
    .pop        (buf_pop),
    .flush      (redirect_valid),
    .count      (buf_count),
    .empty      (buf_empty),
    .full       (buf_full),
    .head       (buf_head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a cycle-level memory model feeds responses,
// a scoreboard queue holds the expected buffer contents, and tables hold the
// expected streaming and PC-wrap results.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0)
  logic        reset = 1'b1;
  logic        stall_if = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instn;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  // Wrap instance (RESET_PC = 0xFFFF_FFF8)
  logic        w_reset = 1'b1;
  logic        w_stall_if = 1'b0;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_gnt = 1'b1;
  logic        w_imem_rvalid = 1'b0;
  logic [31:0] w_imem_rdata = '0;
  logic        w_if_valid;
  logic [31:0] w_if_instn;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_pc_plus4;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .DEPTH     (2),
    .NOP_INSTN (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_if       (stall_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instn       (if_instn),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  instr_fetch_unit #(
    .RESET_PC  (32'hFFFF_FFF8),
    .DEPTH     (2),
    .NOP_INSTN (32'h0000_0000)
  ) dut_w (
    .clk            (clk),
    .reset          (w_reset),
    .stall_if       (w_stall_if),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .imem_req       (w_imem_req),
    .imem_addr      (w_imem_addr),
    .imem_gnt       (w_imem_gnt),
    .imem_rvalid    (w_imem_rvalid),
    .imem_rdata     (w_imem_rdata),
    .if_valid       (w_if_valid),
    .if_instn       (w_if_instn),
    .if_pc          (w_if_pc),
    .if_pc_plus4    (w_if_pc_plus4)
  );

  // Table record: memory address requested, data the memory returns for it,
  // and the entry expected at the IF/ID interface.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc_plus4;
  } vec_t;

  vec_t stream_tbl[3];
  vec_t wrap_tbl[3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Memory model and scoreboard state
  int           lat = 1;
  bit           pend_v = 1'b0;
  bit           pend_drop = 1'b0;
  logic [31:0]  pend_addr = '0;
  int           pend_cnt = 0;
  fetch_entry_t exp_q[$];
  fetch_entry_t pop_q[$];
  logic [31:0]  grant_q[$];
  int           grant_cyc[$];
  int           pop_cyc[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, sample 1 time unit
  // later, then advance the model to the state it will have after the rising edge.
  task automatic cycle(input logic stall, input logic redir, input logic [31:0] rpc);
    fetch_entry_t e;
    bit           fire;
    bit           fire_drop;
    logic [31:0]  fire_addr;
    @(negedge clk);
    cyc++;
    stall_if       = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_gnt       = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    fire      = pend_v && (pend_cnt == 0);
    fire_drop = pend_drop;
    fire_addr = pend_addr;
    if (fire) begin
      imem_rvalid = 1'b1;
      imem_rdata  = fire_drop ? 32'hDEAD_BEEF : mem_data(fire_addr);
    end
    #1;
    check("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
    if (!if_valid) begin
      check("nop_when_empty", if_instn, NOP_INSTN);
    end else if (!stall && !redir) begin
      pop_q.push_back('{if_pc, if_pc_plus4, if_instn});
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'(if_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", if_pc, e.pc);
        check("pop_pc_plus4", if_pc_plus4, e.pc_plus4);
        check("pop_instn", if_instn, e.instn);
      end
    end
    if (fire) begin
      pend_v = 1'b0;
      if (!fire_drop && !redir) begin
        exp_q.push_back('{fire_addr, fire_addr + 32'd4, mem_data(fire_addr)});
      end
    end
    if (redir) begin
      exp_q.delete();
      if (pend_v) pend_drop = 1'b1;
    end
    if (imem_req) begin
      check("one_outstanding", 32'(pend_v), 32'd0);
      check("no_req_on_redirect", 32'(redir), 32'd0);
      check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
      grant_q.push_back(imem_addr);
      grant_cyc.push_back(cyc);
      pend_v    = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = lat - 1;
      pend_drop = 1'b0;
    end else if (pend_v && pend_cnt > 0) begin
      pend_cnt--;
    end
  endtask

  task automatic model_clear();
    pend_v = 1'b0;
    pend_drop = 1'b0;
    exp_q.delete();
    pop_q.delete();
    grant_q.delete();
    grant_cyc.delete();
    pop_cyc.delete();
  endtask

  // Reset for two edges, then check the outputs in the first cycle after reset.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall_if = 1'b0;
    redirect_valid = 1'b0;
    imem_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instn", if_instn, NOP_INSTN);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_pc_plus4", if_pc_plus4, 32'h0);
  endtask

  // Run normal cycles until a new grant is logged, bounded.
  task automatic wait_grant();
    int n;
    n = grant_q.size();
    for (int i = 0; i < 20 && grant_q.size() == n; i++) cycle(1'b0, 1'b0, '0);
    check("grant_wait", 32'(grant_q.size() > n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int p0;
    int rcyc;
    bit          wp;
    logic [31:0] wa;
    logic [31:0] w_grants[$];
    fetch_entry_t w_pops[$];

    stream_tbl[0] = '{32'h0000_0000, 32'h5A5A_0000, 32'h0000_0000, 32'h0000_0004};
    stream_tbl[1] = '{32'h0000_0004, 32'h5A5A_0004, 32'h0000_0004, 32'h0000_0008};
    stream_tbl[2] = '{32'h0000_0008, 32'h5A5A_0008, 32'h0000_0008, 32'h0000_000C};
    wrap_tbl[0]   = '{32'hFFFF_FFF8, 32'h0000_0007, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    wrap_tbl[1]   = '{32'hFFFF_FFFC, 32'h0000_0003, 32'hFFFF_FFFC, 32'h0000_0000};
    wrap_tbl[2]   = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0004};

    // Streaming with gnt always high and one-cycle response latency
    do_reset();
    lat = 1;
    repeat (12) cycle(1'b0, 1'b0, '0);
    check("stream_grants", 32'(grant_q.size() >= 3 && pop_q.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < grant_q.size() && i < pop_q.size()) begin
        check("stream_addr", grant_q[i], stream_tbl[i].addr);
        check("stream_pc", pop_q[i].pc, stream_tbl[i].exp_pc);
        check("stream_pc_plus4", pop_q[i].pc_plus4, stream_tbl[i].exp_pc_plus4);
        check("stream_instn", pop_q[i].instn, stream_tbl[i].rdata);
      end
    end
    if (grant_cyc.size() >= 2 && pop_cyc.size() >= 1) begin
      check("first_latency", 32'(pop_cyc[0] - grant_cyc[0]), 32'd2);
      check("issue_rate", 32'(grant_cyc[1] - grant_cyc[0]), 32'd2);
    end

    // Stall held for 10 cycles: buffer fills and requests stop
    repeat (10) cycle(1'b1, 1'b0, '0);
    check("stall_req_low", 32'(imem_req), 32'd0);
    check("stall_head_valid", 32'(if_valid), 32'd1);
    pop_q.delete();
    repeat (8) cycle(1'b0, 1'b0, '0);
    check("release_pops", 32'(pop_q.size() >= 3), 32'd1);
    for (int i = 1; i < pop_q.size(); i++) begin
      check("release_order", pop_q[i].pc, pop_q[i-1].pc + 32'd4);
    end

    // Redirect while waiting; stale response arrives 3 cycles later
    lat = 4;
    wait_grant();
    lat = 1;
    cycle(1'b0, 1'b1, 32'h0000_0102);
    rcyc = cyc;
    n0 = grant_q.size();
    p0 = pop_q.size();
    repeat (6) cycle(1'b0, 1'b0, '0);
    check("redir_wait_regrant", 32'(grant_q.size() > n0), 32'd1);
    if (grant_q.size() > n0) begin
      check("redir_wait_addr", grant_q[n0], 32'h0000_0100);
      check("redir_wait_delay", 32'(grant_cyc[n0] - rcyc), 32'd4);
    end
    for (int i = p0; i < pop_q.size(); i++) begin
      check("stale_not_seen", 32'(pop_q[i].instn == 32'hDEAD_BEEF), 32'd0);
    end

    // Redirect in the same cycle as the response
    lat = 1;
    wait_grant();
    cycle(1'b0, 1'b1, 32'h0000_0200);
    n0 = grant_q.size();
    cycle(1'b0, 1'b0, '0);
    check("redir_rv_if_valid", 32'(if_valid), 32'd0);
    check("redir_rv_req", 32'(imem_req), 32'd1);
    check("redir_rv_addr", imem_addr, 32'h0000_0200);
    check("redir_rv_grant", 32'(grant_q.size()), 32'(n0 + 1));

    // Redirect while stalled: flush still happens
    repeat (4) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h0000_0300);
    cycle(1'b1, 1'b0, '0);
    check("redir_stall_flush", 32'(if_valid), 32'd0);

    // Reset in S_WAIT with a stray response the next cycle
    wait_grant();
    @(negedge clk);
    reset = 1'b1;
    stall_if = 1'b0;
    redirect_valid = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check("reset_cycle_no_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_0001;
    #1;
    check("post_rst_req", 32'(imem_req), 32'd0);
    check("post_rst_valid", 32'(if_valid), 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    model_clear();
    #1;
    check("stray_not_pushed", 32'(if_valid), 32'd0);
    check("first_req_after_rst", 32'(imem_req), 32'd1);
    check("first_addr_after_rst", imem_addr, 32'h0000_0000);
    if (imem_req) begin
      grant_q.push_back(imem_addr);
      pend_v = 1'b1;
      pend_addr = imem_addr;
      pend_cnt = 0;
    end
    repeat (4) cycle(1'b0, 1'b0, '0);
    check("post_rst_pop", 32'(pop_q.size() >= 1), 32'd1);
    if (pop_q.size() >= 1) check("post_rst_pop_pc", pop_q[0].pc, 32'h0000_0000);

    // PC wrap on the second instance
    @(negedge clk);
    w_reset = 1'b0;
    w_imem_rvalid = 1'b0;
    #1;
    check("w_rst_req", 32'(w_imem_req), 32'd0);
    wp = 1'b0;
    wa = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      w_imem_rvalid = wp;
      w_imem_rdata  = wp ? ~wa : 32'h0;
      wp = 1'b0;
      #1;
      if (w_if_valid) w_pops.push_back('{w_if_pc, w_if_pc_plus4, w_if_instn});
      if (w_imem_req && w_imem_gnt) begin
        w_grants.push_back(w_imem_addr);
        wp = 1'b1;
        wa = w_imem_addr;
      end
    end
    check("w_counts", 32'(w_grants.size() >= 3 && w_pops.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < w_grants.size() && i < w_pops.size()) begin
        check("w_addr", w_grants[i], wrap_tbl[i].addr);
        check("w_pc", w_pops[i].pc, wrap_tbl[i].exp_pc);
        check("w_pc_plus4", w_pops[i].pc_plus4, wrap_tbl[i].exp_pc_plus4);
        check("w_instn", w_pops[i].instn, wrap_tbl[i].rdata);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
